sign_ext: RTL and testbench
===========================

// Module: sign_ext
// PURPOSE
// - MIPS immediate extender: widens a 16-bit instruction immediate to a 32-bit datapath operand.
// - Sits between the instruction decoder and the ALU-B / branch-target muxes.
// - Default mode is two's-complement sign extension.
// - Output is registered: one pipeline stage with a valid qualifier.
// PARAMETERS
// - IN_W   16  immediate width
// - OUT_W  32  extended operand width (must be > IN_W)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      reset, asynchronous, active-low
// - a          in   16     immediate (instr[15:0])
// - mode       in   2      00 sign-ext, 01 zero-ext, 10 upper (lui), 11 sign-ext<<2 (branch offset)
// - in_valid   in   1      a/mode valid this cycle
// - b          out  32     extended result (registered)
// - out_valid  out  1      b updated on previous edge
// - b_comb     out  32     combinational result; present only with SIGNEXT_COMB_OUT_EN
// BEHAVIOUR
// - Single clock; reset is asynchronous, active-low.
// - rst_n low: b=32'h0000_0000, out_valid=0, immediately and independently of clk.
// - Result function f(a, mode):
//   - 00: {{16{a[15]}}, a}
//   - 01: {16'h0000, a}
//   - 10: {a, 16'h0000}
//   - 11: {{14{a[15]}}, a, 2'b00}; the two bits shifted out past bit 31 are dropped.
// - Rising clk with in_valid=1: b <= f(a, mode), out_valid <= 1. Latency is 1 cycle.
// - Rising clk with in_valid=0: b holds its previous value, out_valid <= 0.
// - Back-to-back valids are accepted every cycle; no backpressure, no stall input.
// - Boundaries:
//   - a[15] alone selects the fill value; 16'h7FFF is the largest positive and 16'h8000 the most negative.
//   - 16'hFFFF in mode 00 gives 32'hFFFF_FFFF.
// - rst_n deasserting mid-stream: first valid capture happens on the first edge with rst_n=1.
// - Unknown/X on mode while in_valid=1 must not be relied on; an unlisted encoding cannot occur (2-bit full decode).
// CONFIGURATION
// - SIGNEXT_COMB_OUT_EN defined: adds port b_comb = f(a, mode), purely combinational, zero latency, unaffected by rst_n or in_valid.
// - Not defined: b_comb port absent; only the registered path exists.
// TESTING
// - Reset: rst_n=0 asynchronously mid-cycle -> b=0, out_valid=0 immediately.
// - Mode 00 sequence, one per cycle, in_valid=1: 16'h1000, 16'h0001, 16'h7FFF, 16'h9000, 16'h9001, 16'hFFFF.
//   - Required b one cycle later: 32'h00001000, 32'h00000001, 32'h00007FFF, 32'hFFFF9000, 32'hFFFF9001, 32'hFFFFFFFF.
// - Mode 01 with a=16'h9000 -> b=32'h00009000. Mode 10 with a=16'h1234 -> b=32'h12340000.
// - Mode 11: a=16'hFFFF -> b=32'hFFFFFFFC; a=16'h4000 -> b=32'h00010000.
// - Hold: valid a=16'h8000 then in_valid=0 with a=16'h0001 -> b stays 32'hFFFF8000, out_valid=0.
// - With SIGNEXT_COMB_OUT_EN: a=16'h9001, mode=00, rst_n=0 -> b_comb=32'hFFFF9001 while b=0.

Source files
------------

// File: rtl/sign_ext.sv
// sign_ext: registered MIPS immediate extender (sign, zero, lui, branch offset).
// Define SIGNEXT_COMB_OUT_EN to expose the unregistered result on b_comb.
module sign_ext #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  a,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] b,
    output logic             out_valid
`ifdef SIGNEXT_COMB_OUT_EN
    ,
    output logic [OUT_W-1:0] b_comb
`endif
);
    logic [OUT_W-1:0] sx, zx, f;
    assign sx = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
    assign zx = {{(OUT_W-IN_W){1'b0}}, a};
    // Branch offset shifts the sign-extended value, so its top two bits fall off.
    always_comb f = mode == 2'b00 ? sx :
                    mode == 2'b01 ? zx :
                    mode == 2'b10 ? zx << (OUT_W-IN_W) : sx << 2;
`ifdef SIGNEXT_COMB_OUT_EN
    assign b_comb = f;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) b <= f;
        end
    end
endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: directed checks of the registered immediate extender.
module tb_sign_ext;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [1:0]  mode = '0;
    logic        in_valid = 1'b0;
    logic [31:0] b;
    logic        out_valid;
`ifdef SIGNEXT_COMB_OUT_EN
    logic [31:0] b_comb;
`endif
    int n_chk = 0;
    int n_fail = 0;

    sign_ext dut (
        .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .in_valid(in_valid),
        .b(b), .out_valid(out_valid)
`ifdef SIGNEXT_COMB_OUT_EN
        , .b_comb(b_comb)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] av, input logic [1:0] mv, input logic v);
        @(negedge clk);
        a = av;
        mode = mv;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m0_a [6] = '{16'h1000, 16'h0001, 16'h7FFF, 16'h9000, 16'h9001, 16'hFFFF};
    logic [31:0] m0_b [6] = '{32'h00001000, 32'h00000001, 32'h00007FFF,
                              32'hFFFF9000, 32'hFFFF9001, 32'hFFFFFFFF};

    initial begin
        #1;
        chk("reset_b", b, 32'h0);
        chk("reset_ov", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(m0_a[i], 2'b00, 1'b1);
            chk($sformatf("m00_b[%0d]", i), b, m0_b[i]);
            chk($sformatf("m00_ov[%0d]", i), {31'b0, out_valid}, 32'h1);
        end
        step(16'h9000, 2'b01, 1'b1);
        chk("m01_9000", b, 32'h00009000);
        step(16'h1234, 2'b10, 1'b1);
        chk("m10_1234", b, 32'h12340000);
        step(16'hFFFF, 2'b11, 1'b1);
        chk("m11_ffff", b, 32'hFFFFFFFC);
        step(16'h4000, 2'b11, 1'b1);
        chk("m11_4000", b, 32'h00010000);
        step(16'h8000, 2'b00, 1'b1);
        chk("hold_load", b, 32'hFFFF8000);
        step(16'h0001, 2'b00, 1'b0);
        chk("hold_b", b, 32'hFFFF8000);
        chk("hold_ov", {31'b0, out_valid}, 32'h0);
        step(16'h1234, 2'b10, 1'b1);
        chk("pre_rst_b", b, 32'h12340000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_b", b, 32'h0);
        chk("async_rst_ov", {31'b0, out_valid}, 32'h0);
        a = 16'h9001;
        mode = 2'b00;
        in_valid = 1'b1;
        #1;
`ifdef SIGNEXT_COMB_OUT_EN
        chk("comb_in_rst", b_comb, 32'hFFFF9001);
`endif
        @(posedge clk);
        #1;
        chk("rst_hold_b", b, 32'h0);
        chk("rst_hold_ov", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_cap_b", b, 32'hFFFF9001);
        chk("first_cap_ov", {31'b0, out_valid}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
